// File: rtl/lza_shift_corrector.sv
// Two-stage normalizer after the LZA / detection-tree pair: S1 applies the
// predicted coarse shift, S2 applies the one-bit correction and drives outputs.
module lza_shift_corrector #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 3,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_sum,
    input  logic [SHIFT_WIDTH-1:0] in_pred_shift,
    input  logic                   in_nshift_correct,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [SHIFT_WIDTH:0]   out_shift,
    output logic                   out_zero,
    output logic                   out_norm_err,
    output logic [CNT_WIDTH-1:0]   corr_count,
    input  logic                   corr_clear
);

    logic                   s1_valid, s1_corr, s1_zero;
    logic [DATA_WIDTH-1:0]  s1_data;
    logic [SHIFT_WIDTH-1:0] s1_pred;

    logic                   s2_valid, s2_corr, s2_zero;
    logic [DATA_WIDTH-1:0]  s2_data;
    logic [SHIFT_WIDTH:0]   s2_shift;

    logic                   s2_can_load, s1_adv, accept;
    logic [DATA_WIDTH-1:0]  coarse;

    assign s2_can_load = ~s2_valid | out_ready;
    assign s1_adv      = s1_valid & s2_can_load;
    assign in_ready    = ~s1_valid | s2_can_load;
    assign accept      = in_valid & in_ready;

    // Shift amounts >= DATA_WIDTH push every bit out, yielding zero data.
    assign coarse = in_sum << in_pred_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_pred  <= '0;
            s1_corr  <= 1'b0;
            s1_zero  <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= coarse;
                s1_pred  <= in_pred_shift;
                s1_corr  <= in_nshift_correct;
                s1_zero  <= (in_sum == '0);
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_shift <= '0;
            s2_corr  <= 1'b0;
            s2_zero  <= 1'b0;
        end else if (s2_can_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                // A zero sum overrides the correction: no shift, nothing counted.
                s2_data  <= s1_zero ? '0 : (s1_corr ? (s1_data << 1) : s1_data);
                s2_shift <= s1_zero ? '0 : ({1'b0, s1_pred} + {{SHIFT_WIDTH{1'b0}}, s1_corr});
                s2_corr  <= s1_corr & ~s1_zero;
                s2_zero  <= s1_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count <= '0;
        end else if (corr_clear) begin
            corr_count <= '0;
        end else if (s2_valid && out_ready && s2_corr && !(&corr_count)) begin
            corr_count <= corr_count + 1'b1;
        end
    end

    assign out_valid    = s2_valid;
    assign out_data     = s2_data;
    assign out_shift    = s2_shift;
    assign out_zero     = s2_zero;
    assign out_norm_err = s2_valid & ~s2_zero & ~s2_data[DATA_WIDTH-1];

endmodule

// File: tb/tb_lza_shift_corrector.sv
// Directed bench for lza_shift_corrector: datapath vectors, backpressure,
// counter saturation/clear and mid-stream reset.
module tb_lza_shift_corrector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_nshift_correct;
    logic [7:0] in_sum;
    logic [2:0] in_pred_shift;
    logic       out_valid, out_ready, out_zero, out_norm_err, corr_clear;
    logic [7:0] out_data, corr_count;
    logic [3:0] out_shift;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lza_shift_corrector #(.DATA_WIDTH(8), .SHIFT_WIDTH(3), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .in_pred_shift(in_pred_shift), .in_nshift_correct(in_nshift_correct),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shift(out_shift), .out_zero(out_zero), .out_norm_err(out_norm_err),
        .corr_count(corr_count), .corr_clear(corr_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [7:0] s, input logic [2:0] p, input logic c);
        in_valid = v; in_sum = s; in_pred_shift = p; in_nshift_correct = c;
    endtask

    logic [7:0] got[$];
    int sent;

    initial begin
        rst = 1'b1; out_ready = 1'b1; corr_clear = 1'b0;
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_corr_count", corr_count, 0);
        chk("rst_out_data", out_data, 0);
        #11 rst = 1'b0;

        // Predicted exact, then corrected, back to back
        drive(1'b1, 8'b0001_0110, 3'd3, 1'b0);
        tick();
        chk("lat1_no_valid", out_valid, 0);
        drive(1'b1, 8'b0000_1011, 3'd3, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("exact_valid", out_valid, 1);
        chk("exact_data", out_data, 8'b1011_0000);
        chk("exact_shift", out_shift, 3);
        chk("exact_norm_err", out_norm_err, 0);
        chk("exact_cc", corr_count, 0);
        tick();
        chk("corr_data", out_data, 8'b1011_0000);
        chk("corr_shift", out_shift, 4);
        chk("corr_norm_err", out_norm_err, 0);
        chk("corr_cc_before", corr_count, 0);
        tick();
        chk("corr_cc_after", corr_count, 1);
        chk("corr_drained", out_valid, 0);

        // Zero result then misprediction
        drive(1'b1, 8'h00, 3'd5, 1'b1);
        tick();
        drive(1'b1, 8'b0000_0011, 3'd3, 1'b0);
        tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("zero_flag", out_zero, 1);
        chk("zero_data", out_data, 0);
        chk("zero_shift", out_shift, 0);
        chk("zero_norm_err", out_norm_err, 0);
        tick();
        chk("mis_data", out_data, 8'b0001_1000);
        chk("mis_norm_err", out_norm_err, 1);
        chk("mis_zero", out_zero, 0);
        chk("zero_not_counted", corr_count, 1);
        tick();

        // Full shift-out: pred 7 plus correction
        drive(1'b1, 8'h01, 3'd7, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        chk("full_data", out_data, 0);
        chk("full_shift", out_shift, 8);
        chk("full_norm_err", out_norm_err, 1);
        tick();
        chk("full_cc", corr_count, 2);

        // Backpressure: 4 beats, out_ready low for the first 4 cycles
        sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (sent < 4) drive(1'b1, 8'h01, 3'(sent), 1'b0);
            else drive(1'b0, 8'h00, 3'd0, 1'b0);
            out_ready = (cyc >= 4);
            #1;
            if (cyc == 2) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_two_accepted", sent, 2);
            end
            if (cyc == 3) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_data", out_data, 8'h01);
            end
            if (cyc == 4) chk("bp_full_accept", in_ready, 1);
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && in_ready) sent++;
            tick();
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("bp_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 8'hxx, 8'h01 << i);

        // Saturation: 260 corrected nonzero beats on top of count 2
        out_ready = 1'b1;
        drive(1'b1, 8'h01, 3'd0, 1'b1);
        for (int i = 0; i < 260; i++) tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        tick(); tick(); tick();
        chk("sat_cc", corr_count, 255);

        // Clear coincident with a corrected handshake wins
        drive(1'b1, 8'h40, 3'd0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        chk("clr_valid", out_valid, 1);
        corr_clear = 1'b1;
        tick();
        corr_clear = 1'b0;
        chk("clr_cc", corr_count, 0);
        drive(1'b1, 8'h40, 3'd0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        tick(); tick();
        chk("post_clr_cc", corr_count, 1);

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        drive(1'b1, 8'h33, 3'd1, 1'b0);
        tick(); tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        #1;
        chk("pre_rst_full", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_cc", corr_count, 0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'h05, 3'd5, 1'b0);
        tick();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        chk("post_rst_lat1", out_valid, 0);
        tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 8'hA0);
        chk("post_rst_shift", out_shift, 5);
        tick();
        chk("post_rst_drained", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
